inst_i_enc: RTL and testbench
=============================

# inst_i_enc

I-type instruction encoder: the write-side counterpart of the I-type decoder. It accepts decoded fields (kind, funct3, imm, rs1, rd) over a valid/ready handshake and packs them into 32-bit RV32I I-type words. Each word is tagged with a sequential instruction-memory address and buffered in a 2-entry FIFO toward the program loader / instruction-memory write port. It is used by the bench-side program loader and by self-test ROM generation.

## Interface
- ADDR_W, 8, width of word address counter
- BASE_ADDR, 0, address assigned to first word after reset/clear
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  sync flush: empties FIFO, address := BASE_ADDR, wrapped := 0
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept
- in_kind  in  2  0=OP-IMM (0010011), 1=LOAD (0000011), 2=JALR (1100111), 3=reserved
- in_funct3  in  3  funct3 field
- in_imm  in  12  imm[11:0]
- in_rs1  in  5  source register
- in_rd  in  5  destination register
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_word
- out_err  out  1  head word was replaced by NOP due to illegal input
- wrapped  out  1  sticky: address counter has wrapped

## Operation
- Encoding: word = {imm, rs1, funct3, rd, opcode(kind)}.
- Accept when in_valid && in_ready. The encoded word, current address and err are pushed into the FIFO, and the address increments.
- Address counter: ADDR_W bits, modulo 2^ADDR_W. The transition from 2^ADDR_W-1 to 0 sets wrapped (sticky until clear/reset).
- Illegal input: kind=3, or JALR with funct3≠000. Pushes NOP 0x00000013 with err=1; the address still increments.
- FIFO: 2 entries, in_ready = !full.
  - Push and pop in the same cycle are allowed when not full.
  - When full, in_ready=0 even if out_ready=1. There is no same-cycle pass-through.
- out_word/out_addr/out_err show the head entry when out_valid. When empty they read all zeros.
- clear has priority over an accept in the same cycle: the input is not taken (in_ready forced 0 while clear=1).
- Reset or clear mid-stream discards buffered words. No partial output is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, out_word=0, out_addr=0, out_err=0, wrapped=0, internal address=BASE_ADDR.
- Latency: accept in cycle N, out_valid=1 in cycle N+1 (FIFO empty, no clear).
- Throughput: 1 word/cycle with out_ready held high.
- With out_ready=0, at most two accepts are possible, then in_ready=0 from the following cycle until a pop.
- Outputs are registered or FIFO-head driven, with no combinational path from in_* to out_*.
- in_ready depends only on FIFO state and clear.

## Configuration
- INST_I_ENC_RANGE_CHECK_EN defined: shift legality is checked for OP-IMM.
  - funct3=001 (SLLI) requires imm[11:5]=0000000.
  - funct3=101 (SRLI/SRAI) requires imm[11:5] ∈ {0000000, 0100000}.
  - A violation produces NOP with err=1.
- Undefined: OP-IMM fields pass through verbatim. err arises only from kind=3 or JALR funct3≠000.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants OPC_OP_IMM, OPC_LOAD, OPC_JALR
  - funct3 constants for shifts
  - I-kind encoding constants
  - INSN_NOP = 32'h00000013
- Sub-module inst_i_enc_fifo: 2-entry, parameterised-width FIFO with clear. Payload = {err, addr, word}.
- The top level holds the encode logic, legality check and address counter.

## Test plan
- Reset, then ADDI x5,x1,-1 (kind0, f3=000, imm=FFF, rs1=1, rd=5) -> next cycle out_valid=1, out_word=0xFFF08293, out_addr=0, out_err=0.
- LW x10,8(x2) then JALR x1,0(x6) back-to-back, out_ready=1 -> 0x00812503 @0, 0x000300E7 @1, one per cycle.
- out_ready=0, push 3 words -> first two accepted, in_ready=0 afterward. Raise out_ready -> words drain in order and the third is accepted.
- ADDR_W=2, push 5 words -> addresses 0,1,2,3,0; wrapped=1 after the fourth. Then clear -> FIFO empty, next word at address 0, wrapped=0.
- kind=3, and JALR with f3=010 -> both 0x00000013 with out_err=1; addresses still advance.
- SRAI x3,x3,4 (imm=0x404, f3=101) -> 0x4041D193. imm=0x204, f3=101 -> NOP+err with INST_I_ENC_RANGE_CHECK_EN, 0x2041D193 without.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I I-type encoding constants and helpers shared by the encoder and its users.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_SLLI    = 3'b001;
    localparam logic [2:0] F3_SRLI    = 3'b101;  // SRAI shares funct3 with SRLI
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] SHAMT_HI_LOGIC = 7'b0000000;
    localparam logic [6:0] SHAMT_HI_ARITH = 7'b0100000;

    localparam logic [31:0] INSN_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        KIND_OP_IMM = 2'd0,
        KIND_LOAD   = 2'd1,
        KIND_JALR   = 2'd2,
        KIND_RSVD   = 2'd3
    } i_kind_e;

    typedef struct packed {
        i_kind_e     kind;
        logic [2:0]  funct3;
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rd;
    } i_fields_t;

    function automatic logic [6:0] kind_opcode(input i_kind_e kind);
        logic [6:0] opc;
        opc = OPC_OP_IMM;
        case (kind)
            KIND_OP_IMM: opc = OPC_OP_IMM;
            KIND_LOAD:   opc = OPC_LOAD;
            KIND_JALR:   opc = OPC_JALR;
            default:     opc = OPC_OP_IMM;
        endcase
        return opc;
    endfunction

    function automatic logic [31:0] pack_i(input i_fields_t f);
        return {f.imm, f.rs1, f.funct3, f.rd, kind_opcode(f.kind)};
    endfunction

    function automatic logic base_legal(input i_fields_t f);
        logic ok;
        ok = 1'b1;
        if (f.kind == KIND_RSVD) ok = 1'b0;
        if (f.kind == KIND_JALR && f.funct3 != F3_JALR) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic shift_legal(input i_fields_t f);
        logic ok;
        ok = 1'b1;
        if (f.kind == KIND_OP_IMM) begin
            if (f.funct3 == F3_SLLI && f.imm[11:5] != SHAMT_HI_LOGIC) ok = 1'b0;
            if (f.funct3 == F3_SRLI && f.imm[11:5] != SHAMT_HI_LOGIC
                && f.imm[11:5] != SHAMT_HI_ARITH) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/inst_i_enc_fifo.sv
// Two-entry FIFO with synchronous clear; head reads zero when empty.
module inst_i_enc_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_ok) rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_i_enc.sv
// RV32I I-type encoder: packs fields, tags each word with a sequential address, buffers in a 2-entry FIFO.
// Optional macro INST_I_ENC_RANGE_CHECK_EN adds OP-IMM shift-immediate legality checking.
module inst_i_enc
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic [11:0]       in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              wrapped
);

    localparam int                PW   = 1 + ADDR_W + 32;
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;
    logic              fifo_full, fifo_empty;
    logic              accept;
    logic              legal;
    i_fields_t         fields;
    logic [31:0]       enc_word;
    logic [PW-1:0]     push_data, head;

    assign fields = '{kind:   i_kind_e'(in_kind),
                      funct3: in_funct3,
                      imm:    in_imm,
                      rs1:    in_rs1,
                      rd:     in_rd};

`ifdef INST_I_ENC_RANGE_CHECK_EN
    assign legal = base_legal(fields) && shift_legal(fields);
`else
    assign legal = base_legal(fields);
`endif

    assign enc_word  = legal ? pack_i(fields) : INSN_NOP;
    assign push_data = {~legal, addr_q, enc_word};

    // clear wins over an accept in the same cycle
    assign in_ready = !fifo_full && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        if (clear) begin
            addr_d    = BASE;
            wrapped_d = 1'b0;
        end else if (accept) begin
            addr_d = addr_q + 1'b1;
            if (&addr_q) wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE;
            wrapped_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
        end
    end

    inst_i_enc_fifo #(.W(PW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (accept),
        .push_data (push_data),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign out_valid                     = !fifo_empty;
    assign {out_err, out_addr, out_word} = head;
    assign wrapped                       = wrapped_q;

endmodule

// File: tb/tb_inst_i_enc.sv
// Directed bench for inst_i_enc: default instance plus an ADDR_W=2 instance for wrap coverage.
module tb_inst_i_enc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_kind = '0;
    logic [2:0]  in_funct3 = '0;
    logic [11:0] in_imm = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rd = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_err, wrapped;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
    logic        in_ready2, out_valid2, out_err2, wrapped2;
    logic [31:0] out_word2;
    logic [1:0]  out_addr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_i_enc u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .out_err(out_err),
        .wrapped(wrapped)
    );

    inst_i_enc #(.ADDR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rd(in_rd),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_word(out_word2), .out_addr(out_addr2), .out_err(out_err2),
        .wrapped(wrapped2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] f3, input logic [11:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_kind   = k;
        in_funct3 = f3;
        in_imm    = imm;
        in_rs1    = rs1;
        in_rd     = rd;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] w, input logic [7:0] a, input logic e);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".word"}, out_word, w);
        chk({tag, ".addr"}, {24'd0, out_addr}, {24'd0, a});
        chk({tag, ".err"}, {31'd0, out_err}, {31'd0, e});
    endtask

    initial begin
        // reset
        #12;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_word", out_word, 32'd0);
        chk("rst.out_addr", {24'd0, out_addr}, 32'd0);
        chk("rst.out_err", {31'd0, out_err}, 32'd0);
        chk("rst.wrapped", {31'd0, wrapped}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ADDI x5,x1,-1: visible the cycle after accept
        drive(2'd0, 3'b000, 12'hFFF, 5'd1, 5'd5);
        tick();
        in_valid = 1'b0;
        head("addi", 32'hFFF08293, 8'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("addi.drain", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // LW then JALR back-to-back, out_ready high
        do_clear();
        out_ready = 1'b1;
        drive(2'd1, 3'b010, 12'h008, 5'd2, 5'd10);
        tick();
        head("lw", 32'h00812503, 8'd0, 1'b0);
        drive(2'd2, 3'b000, 12'h000, 5'd6, 5'd1);
        tick();
        in_valid = 1'b0;
        head("jalr", 32'h000300E7, 8'd1, 1'b0);
        tick();
        chk("b2b.empty", {31'd0, out_valid}, 32'd0);

        // backpressure: three words, FIFO holds two
        do_clear();
        out_ready = 1'b0;
        drive(2'd0, 3'b000, 12'h001, 5'd0, 5'd1);
        tick();
        chk("bp.ready1", {31'd0, in_ready}, 32'd1);
        drive(2'd0, 3'b000, 12'h002, 5'd0, 5'd2);
        tick();
        chk("bp.ready2", {31'd0, in_ready}, 32'd0);
        drive(2'd0, 3'b000, 12'h003, 5'd0, 5'd3);
        tick();
        chk("bp.ready3", {31'd0, in_ready}, 32'd0);
        head("bp.a", 32'h00100093, 8'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        head("bp.b", 32'h00200113, 8'd1, 1'b0);
        chk("bp.ready4", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        head("bp.c", 32'h00300193, 8'd2, 1'b0);
        tick();
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // address wrap on the ADDR_W=2 instance
        do_clear();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(2'd0, 3'b000, 12'(k), 5'd0, 5'd0);
            tick();
            chk($sformatf("wrap.addr%0d", k), {30'd0, out_addr2}, 32'(k % 4));
            chk($sformatf("wrap.word%0d", k), out_word2, (32'(k) << 20) | 32'h13);
            chk($sformatf("wrap.flag%0d", k), {31'd0, wrapped2}, (k >= 3) ? 32'd1 : 32'd0);
        end
        // clear beats a concurrent valid input
        clear = 1'b1;
        #1;
        chk("clr.in_ready", {31'd0, in_ready2}, 32'd0);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr.empty", {31'd0, out_valid2}, 32'd0);
        chk("clr.wrapped", {31'd0, wrapped2}, 32'd0);
        drive(2'd1, 3'b010, 12'h008, 5'd2, 5'd10);
        tick();
        in_valid = 1'b0;
        chk("clr.addr", {30'd0, out_addr2}, 32'd0);
        chk("clr.valid", {31'd0, out_valid2}, 32'd1);
        tick();

        // illegal inputs become NOP with err; address still advances
        do_clear();
        drive(2'd3, 3'b000, 12'h123, 5'd4, 5'd4);
        tick();
        head("ill.rsvd", 32'h00000013, 8'd0, 1'b1);
        drive(2'd2, 3'b010, 12'h000, 5'd6, 5'd1);
        tick();
        in_valid = 1'b0;
        head("ill.jalr", 32'h00000013, 8'd1, 1'b1);
        tick();

        // shift immediates
        do_clear();
        drive(2'd0, 3'b101, 12'h404, 5'd3, 5'd3);
        tick();
        head("srai", 32'h4041D193, 8'd0, 1'b0);
        drive(2'd0, 3'b101, 12'h204, 5'd3, 5'd3);
        tick();
        in_valid = 1'b0;
`ifdef INST_I_ENC_RANGE_CHECK_EN
        head("srx.bad", 32'h00000013, 8'd1, 1'b1);
`else
        head("srx.bad", 32'h2041D193, 8'd1, 1'b0);
`endif
        tick();
        chk("end.empty", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
